// File: rtl/aes256_core_arbiter_if.sv
// Bundle of requester, core and response signals around the AES-256 core arbiter.
// master = arbiter side, slave = queues/core/response consumer side.
interface aes256_core_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]     req_valid_i;
  logic [NUM_REQ-1:0]     req_mode_i;
  logic [NUM_REQ*128-1:0] req_data_i;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic                   core_start_o;
  logic                   core_mode_o;
  logic [127:0]           core_data_o;
  logic                   core_valid_i;
  logic [127:0]           core_data_i;
  logic                   rsp_valid_o;
  logic                   rsp_ready_i;
  logic [ID_W-1:0]        rsp_id_o;
  logic [127:0]           rsp_data_o;
  logic                   rsp_err_o;
  logic                   busy_o;

  modport master (
    input  req_valid_i, req_mode_i, req_data_i, core_valid_i, core_data_i, rsp_ready_i,
    output req_ready_o, core_start_o, core_mode_o, core_data_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );

  modport slave (
    output req_valid_i, req_mode_i, req_data_i, core_valid_i, core_data_i, rsp_ready_i,
    input  req_ready_o, core_start_o, core_mode_o, core_data_o,
           rsp_valid_o, rsp_id_o, rsp_data_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/aes256_core_arbiter.sv
// Round-robin arbiter sharing one AES-256 core among NUM_REQ requesters, one job in flight.
// Define AES_ARB_TIMEOUT_EN to build the core watchdog (TIMEOUT_CYC cycles in RUN/DRAIN).
module aes256_core_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_W        = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input logic                   clk,
  input logic                   rst_n,
  aes256_core_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, RESP} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, gnt_id, scan_id, job_id;
  logic            gnt_found, job_mode, tmo;
  logic [127:0]    job_data, rsp_data;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (1 << ID_W) < NUM_REQ || TIMEOUT_CYC < 2) begin : g_param_chk
    $error("aes256_core_arbiter: unsupported parameter set");
  end

  // Scan downward so the last hit is the first valid requester at or after rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan_id   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      scan_id = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (bus.req_valid_i[scan_id]) begin
        gnt_found = 1'b1;
        gnt_id    = scan_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_found)            state_nxt = RUN;
      RUN:     if (tmo)                  state_nxt = RESP;
               else if (bus.core_valid_i) state_nxt = DRAIN;
      DRAIN:   if (tmo || !bus.core_valid_i) state_nxt = RESP;
      RESP:    if (bus.rsp_ready_i)      state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  // Ready is gated by rst_n so a request held through reset cannot see a grant.
  always_comb begin
    bus.req_ready_o = '0;
    if (rst_n && state == IDLE && gnt_found) bus.req_ready_o[gnt_id] = 1'b1;
    bus.core_start_o = (state == RUN);
    bus.core_mode_o  = job_mode;
    bus.core_data_o  = job_data;
    bus.rsp_valid_o  = (state == RESP);
    bus.rsp_id_o     = job_id;
    bus.rsp_data_o   = rsp_data;
    bus.busy_o       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      job_id   <= '0;
      job_mode <= 1'b0;
      job_data <= '0;
      rsp_data <= '0;
    end else begin
      case (state)
        IDLE: if (gnt_found) begin
          rr_ptr   <= ID_W'((int'(gnt_id) + 1) % NUM_REQ);
          job_id   <= gnt_id;
          job_mode <= bus.req_mode_i[gnt_id];
          job_data <= bus.req_data_i[128*int'(gnt_id) +: 128];
        end
        RUN: if (tmo) rsp_data <= '0;
             else if (bus.core_valid_i) rsp_data <= bus.core_data_i;
        DRAIN: if (tmo) rsp_data <= '0;
        default: ;
      endcase
    end
  end

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err;

  // Fires on the edge where the count would reach TIMEOUT_CYC.
  assign tmo = (state == RUN || state == DRAIN) && (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state == RUN || state == DRAIN) tmo_cnt <= tmo_cnt + CNT_W'(1);
      else                                tmo_cnt <= '0;
      if (state == IDLE && gnt_found) rsp_err <= 1'b0;
      else if (tmo)                   rsp_err <= 1'b1;
    end
  end

  assign bus.rsp_err_o = rsp_err;
`else
  assign tmo           = 1'b0;
  assign bus.rsp_err_o = 1'b0;
`endif
endmodule
